ex_muldiv: RTL

//   Iterative RV32M multiply/divide unit in the execute stage. Consumes the MD_OP, oprand1/2 and

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_abs_neg.sv | 13 +
 rtl/ex_muldiv.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 codes, FSM states
// and small decode helpers used on the operand-entry path.
package md_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // i_rs2 selects which operand's signedness is asked for.
    function automatic logic is_signed(input logic [2:0] f3, input logic i_rs2);
        if (i_rs2)
            return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
        else
            return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement: takes magnitudes of signed operands on entry
// and restores the sign of the product/quotient/remainder on exit.
module md_abs_neg #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide for the execute stage: radix-2 shift-add multiply,
// restoring divide, sign fix-up around an unsigned core; stalls the pipe while busy.
module ex_muldiv
    import md_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            clk,
    input  logic            cpurst,
    input  logic            md_op,
    input  logic [2:0]      md_funct3,
    input  logic [XLEN-1:0] md_oprand1,
    input  logic [XLEN-1:0] md_oprand2,
    input  logic            flush,
    output logic            mult_stall,
    output logic [XLEN-1:0] md_result,
    output logic            md_result_valid
);

    localparam int N  = XLEN / BPC;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [2:0]        r_f3;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;

    logic              w_sa, w_sb, w_div0, w_ovf;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_exc, w_final;
    logic [2*XLEN-1:0] w_acc_next, w_res_in, w_res_out;
    logic              w_res_neg;

    assign w_sa   = is_signed(md_funct3, 1'b0) & md_oprand1[XLEN-1];
    assign w_sb   = is_signed(md_funct3, 1'b1) & md_oprand2[XLEN-1];
    assign w_div0 = is_div(md_funct3) && (md_oprand2 == '0);
    assign w_ovf  = ((md_funct3 == MD_DIV) || (md_funct3 == MD_REM)) &&
                    (md_oprand1 == MIN_NEG) && (md_oprand2 == '1);
    assign w_exc  = w_div0 ? (md_funct3[1] ? md_oprand1 : '1)
                           : (md_funct3[1] ? '0 : md_oprand1);

    md_abs_neg #(.W(XLEN)) u_abs_a (.i_neg(w_sa), .i_val(md_oprand1), .o_val(w_mag_a));
    md_abs_neg #(.W(XLEN)) u_abs_b (.i_neg(w_sb), .i_val(md_oprand2), .o_val(w_mag_b));

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        logic [XLEN:0] v_tmp;
        logic [XLEN:0] v_diff;
        logic [XLEN:0] v_sum;
        v_tmp      = '0;
        v_diff     = '0;
        v_sum      = '0;
        w_acc_next = r_acc;
        for (int k = 0; k < BPC; k++) begin
            if (is_div(r_f3)) begin
                v_tmp  = w_acc_next[2*XLEN-1:XLEN-1];
                v_diff = v_tmp - {1'b0, r_opnd};
                if (!v_diff[XLEN])
                    w_acc_next = {v_diff[XLEN-1:0], w_acc_next[XLEN-2:0], 1'b1};
                else
                    w_acc_next = {v_tmp[XLEN-1:0], w_acc_next[XLEN-2:0], 1'b0};
            end else begin
                v_sum      = {1'b0, w_acc_next[2*XLEN-1:XLEN]} +
                             (w_acc_next[0] ? {1'b0, r_opnd} : '0);
                w_acc_next = {v_sum, w_acc_next[XLEN-1:1]};
            end
        end
    end

    // Product is negated at full width so the MULH* high half carries the borrow.
    assign w_res_in  = is_div(r_f3) ? (r_f3[1] ? {{XLEN{1'b0}}, w_acc_next[2*XLEN-1:XLEN]}
                                               : {{XLEN{1'b0}}, w_acc_next[XLEN-1:0]})
                                    : w_acc_next;
    assign w_res_neg = (is_div(r_f3) && r_f3[1]) ? r_neg_r : r_neg_q;

    md_abs_neg #(.W(2*XLEN)) u_neg_res (.i_neg(w_res_neg), .i_val(w_res_in), .o_val(w_res_out));

    assign w_final = ((r_f3 == MD_MUL) || is_div(r_f3)) ? w_res_out[XLEN-1:0]
                                                        : w_res_out[2*XLEN-1:XLEN];

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_f3     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (md_op) begin
                            r_f3    <= md_funct3;
                            r_cnt   <= CW'(N);
                            r_neg_q <= w_sa ^ w_sb;
                            r_neg_r <= w_sa;
                            if (w_div0 || w_ovf) begin
                                r_result <= w_exc;
                                r_valid  <= 1'b1;
                                r_state  <= ST_DONE;
                            end else begin
                                r_state <= ST_BUSY;
                                if (is_div(md_funct3)) begin
                                    r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                                    r_opnd <= w_mag_b;
                                end else begin
                                    r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                                    r_opnd <= w_mag_a;
                                end
                            end
                        end
                    end
                    ST_BUSY: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_result <= w_final;
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign mult_stall      = ~cpurst & ~flush &
                             (((r_state == ST_IDLE) & md_op) | (r_state == ST_BUSY));
    assign md_result       = r_result;
    assign md_result_valid = r_valid;

endmodule
